// File: rtl/pwm_pkg.sv
// Shared types and helpers for PWM generation/capture blocks.
// duty_bar is the single definition of the 4-level duty thermometer.
package pwm_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int LED_W         = 4;
  localparam int DUTY_W        = 32;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Bit k set when 4*high >= (k+1)*period; all products built from shifts and one add.
  function automatic logic [LED_W-1:0] duty_bar(input logic [DUTY_W-1:0] high,
                                                input logic [DUTY_W-1:0] period);
    logic [DUTY_W+2:0] h4;
    logic [DUTY_W+2:0] p1;
    logic [DUTY_W+2:0] p2;
    logic [DUTY_W+2:0] p3;
    logic [DUTY_W+2:0] p4;
    h4 = {1'b0, high, 2'b00};
    p1 = {3'b000, period};
    p2 = {2'b00, period, 1'b0};
    p3 = p2 + p1;
    p4 = {1'b0, period, 2'b00};
    duty_bar = {h4 >= p4, h4 >= p3, h4 >= p2, h4 >= p1};
  endfunction

endpackage

// File: rtl/pwm_capture_in_sync.sv
// Multi-flop synchronizer for an asynchronous level plus rise/fall detection
// against one extra delayed copy.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   s_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
      s_d        <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw};
      s_d        <= sync_chain[SYNC_STAGES-1];
    end
  end

  assign s    = sync_chain[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time of an external PWM waveform
// in clk cycles, with a sticky no-edge timeout and a duty thermometer.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             timeout_o,
  output logic [LED_W-1:0] led_o
);

  localparam logic [0:0]       S_IDLE    = IDLE;
  localparam logic [0:0]       S_MEASURE = MEASURE;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s;
  logic             rise;
  logic             fall_unused;
  logic [0:0]       state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             period_sat;
  logic             high_sat;

  pwm_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall_unused)
  );

  assign period_sat = (period_cnt == CNT_MAX);
  assign high_sat   = (high_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      period_cnt   <= '0;
      high_cnt     <= '0;
      period_o     <= '0;
      high_o       <= '0;
      meas_valid_o <= 1'b0;
      timeout_o    <= 1'b0;
      led_o        <= '0;
    end else begin
      meas_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          // The first rise only opens a window; nothing is reported yet.
          if (rise) begin
            period_cnt <= CNT_ONE;
            high_cnt   <= CNT_ONE;
            state      <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (rise) begin
            period_o     <= period_cnt;
            high_o       <= high_cnt;
            meas_valid_o <= 1'b1;
            timeout_o    <= 1'b0;
            led_o        <= duty_bar(DUTY_W'(high_cnt), DUTY_W'(period_cnt));
            period_cnt   <= CNT_ONE;
            high_cnt     <= CNT_ONE;
          end else if (period_sat) begin
            // No edge for a full counter span: report a constant level instead.
            timeout_o <= 1'b1;
            led_o     <= {LED_W{s}};
            state     <= S_IDLE;
          end else begin
            period_cnt <= period_cnt + CNT_ONE;
            if (s && !high_sat) begin
              high_cnt <= high_cnt + CNT_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: generated waveforms are turned into expected
// measurements from their rise times and high lengths.
module tb_pwm_capture;

  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             meas_valid_o;
  logic             timeout_o;
  logic [3:0]       led_o;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  period;
    logic [7:0]  high;
    logic [3:0]  led;
  } meas_t;

  meas_t obs_q[$];
  meas_t exp_q[$];
  int    cyc         = 0;
  int    vectors     = 0;
  int    miscompares = 0;
  int    last_rise   = -1;
  int    last_high   = 0;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .period_o    (period_o),
    .high_o      (high_o),
    .meas_valid_o(meas_valid_o),
    .timeout_o   (timeout_o),
    .led_o       (led_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    meas_t m;
    if (meas_valid_o === 1'b1) begin
      m.cyc    = cyc;
      m.period = period_o;
      m.high   = high_o;
      m.led    = led_o;
      obs_q.push_back(m);
    end
  end

  function automatic logic [3:0] exp_led(int h, int p);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (4 * h >= (k + 1) * p);
    return r;
  endfunction

  // Called on a negedge. A rise that closes a window of at most MAXC cycles
  // reports that window SYNC+1 cycles later; a longer gap has timed out.
  task automatic pulse(int h, int l);
    meas_t m;
    if (last_rise >= 0 && (cyc - last_rise) <= MAXC) begin
      m.cyc    = cyc + SYNC + 1;
      m.period = 8'(cyc - last_rise);
      m.high   = 8'(last_high);
      m.led    = exp_led(last_high, cyc - last_rise);
      exp_q.push_back(m);
    end
    last_rise = cyc;
    last_high = h;
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    if (l > 0) begin
      pwm_in = 1'b0;
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    last_rise = -1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (period_o !== '0) begin miscompares++; $display("FAIL reset period_o: got %0d want 0", period_o); end
    vectors++; if (high_o !== '0) begin miscompares++; $display("FAIL reset high_o: got %0d want 0", high_o); end
    vectors++; if (meas_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset meas_valid_o: got %b want 0", meas_valid_o); end
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL reset timeout_o: got %b want 0", timeout_o); end
    vectors++; if (led_o !== 4'b0000) begin miscompares++; $display("FAIL reset led_o: got %b want 0000", led_o); end
    pwm_in = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_p10_h3();
    do_reset();
    repeat (4) pulse(3, 7);
    repeat (10) @(negedge clk);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL p10h3 count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL p10h3[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_duty_switch();
    do_reset();
    repeat (3) pulse(4, 4);
    repeat (3) pulse(7, 1);
    pulse(1, 3);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL switch count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL switch[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_fastest();
    do_reset();
    repeat (6) pulse(1, 1);
    repeat (6) @(negedge clk);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL fast count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL fast[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    pulse(10, 245);
    pulse(10, 247);
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL sat rise-wins timeout_o: got %b want 0", timeout_o); end
    pulse(2, 2);
    vectors++; if (timeout_o !== 1'b1) begin miscompares++; $display("FAIL sat timeout_o: got %b want 1", timeout_o); end
    vectors++; if (led_o !== 4'b0000) begin miscompares++; $display("FAIL sat led_o: got %b want 0000", led_o); end
    vectors++; if ({period_o, high_o} !== {8'd255, 8'd10}) begin miscompares++; $display("FAIL sat hold: got p=%0d h=%0d want p=255 h=10", period_o, high_o); end
    pulse(2, 2);
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL sat clear timeout_o: got %b want 0", timeout_o); end
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL sat count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sat[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_timeout_high();
    int r3;
    do_reset();
    pulse(3, 5);
    pulse(3, 5);
    r3 = cyc;
    pulse(257, 0);
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL toh early: got %b want 0 at %0d after rise", timeout_o, cyc - r3); end
    @(negedge clk);
    vectors++; if (timeout_o !== 1'b1) begin miscompares++; $display("FAIL toh timeout_o: got %b want 1 at %0d after rise", timeout_o, cyc - r3); end
    vectors++; if (led_o !== 4'b1111) begin miscompares++; $display("FAIL toh led_o: got %b want 1111", led_o); end
    vectors++; if ({period_o, high_o} !== {8'd8, 8'd3}) begin miscompares++; $display("FAIL toh hold: got p=%0d h=%0d want p=8 h=3", period_o, high_o); end
    repeat (20) @(negedge clk);
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    pulse(4, 4);
    vectors++; if (timeout_o !== 1'b1) begin miscompares++; $display("FAIL toh first-rise timeout_o: got %b want 1", timeout_o); end
    pulse(4, 4);
    vectors++; if (timeout_o !== 1'b0) begin miscompares++; $display("FAIL toh second-rise timeout_o: got %b want 0", timeout_o); end
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL toh count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL toh[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_timeout_low();
    do_reset();
    repeat (300) @(negedge clk);
    vectors++; if (obs_q.size() !== 0) begin miscompares++; $display("FAIL tol idle pulses: got %0d want 0", obs_q.size()); end
    vectors++; if ({timeout_o, led_o} !== 5'b0) begin miscompares++; $display("FAIL tol idle: got timeout=%b led=%b want 0 0000", timeout_o, led_o); end
    pulse(3, 5);
    pulse(3, 5);
    pulse(3, 300);
    vectors++; if (timeout_o !== 1'b1) begin miscompares++; $display("FAIL tol timeout_o: got %b want 1", timeout_o); end
    vectors++; if (led_o !== 4'b0000) begin miscompares++; $display("FAIL tol led_o: got %b want 0000", led_o); end
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL tol count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL tol[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) pulse(5, 5);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rmid pre count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    pwm_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    pwm_in = 1'b0;
    #1;
    vectors++;
    if ({period_o, high_o, meas_valid_o, timeout_o, led_o} !== '0) begin
      miscompares++;
      $display("FAIL rmid async: got p=%0d h=%0d v=%b t=%b led=%b want all 0", period_o, high_o, meas_valid_o, timeout_o, led_o);
    end
    @(negedge clk);
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    last_rise = -1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse(2, 4);
    vectors++;
    if ({period_o, high_o, led_o} !== '0 || obs_q.size() !== 0) begin
      miscompares++;
      $display("FAIL rmid first-rise: got p=%0d h=%0d led=%b pulses=%0d want all 0", period_o, high_o, led_o, obs_q.size());
    end
    pulse(2, 4);
    pulse(3, 3);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rmid count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rmid[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (40) pulse(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)));
    pulse(1, 5);
    repeat (4) @(negedge clk);
    vectors++;
    if (obs_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL rand count: got %0d pulses want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand[%0d]: got cyc=%0d p=%0d h=%0d led=%b want cyc=%0d p=%0d h=%0d led=%b", i,
                 obs_q[i].cyc, obs_q[i].period, obs_q[i].high, obs_q[i].led, exp_q[i].cyc, exp_q[i].period, exp_q[i].high, exp_q[i].led);
      end
    end
  endtask

  initial begin
    test_reset();
    test_p10_h3();
    test_duty_switch();
    test_fastest();
    test_saturation();
    test_timeout_high();
    test_timeout_low();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
